aes_sub_arbiter: RTL and testbench

Shares a single 128-bit SubBytes datapath (`substitution`, 16 S-boxes) between two requesters: the round datapath (full-state SubBytes) and the key-expansion unit (32-bit SubWord). The block arbitrates, steers operands into the shared S-box array, and registers results into one output slot per requester with valid/ready backpressure. It sits between the round controller / key scheduler and the S-box array in the encryption core, so the design needs no separate 4-S-box SubWord instance.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_sub_arbiter_if.sv | 28 ++
 rtl/aes_rr_arb2.sv | 29 ++
 rtl/substitution.sv | 11 +
 rtl/aes_sub_arbiter.sv | 82 ++++++++
 tb/tb_aes_sub_arbiter.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, grant encoding and the S-box function.
// The S-box is the GF(2^8) inverse (x^254) followed by the affine transform.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_NBYTES = AES_BLK_W / 8;

    localparam logic GNT_ST = 1'b0;
    localparam logic GNT_KS = 1'b1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sub_arbiter_if.sv
// Request, result and status signals between the round/key-schedule side and the arbiter.
interface aes_sub_arbiter_if import aes_pkg::*;;

    logic                    st_valid;
    logic                    st_ready;
    logic [0:AES_BLK_W-1]    st_data;
    logic                    ks_valid;
    logic                    ks_ready;
    logic [0:AES_WORD_W-1]   ks_word;
    logic                    st_out_valid;
    logic                    st_out_ready;
    logic [0:AES_BLK_W-1]    st_out_data;
    logic                    ks_out_valid;
    logic                    ks_out_ready;
    logic [0:AES_WORD_W-1]   ks_out_word;
    logic                    busy;

    modport slave (
        input  st_valid, st_data, ks_valid, ks_word, st_out_ready, ks_out_ready,
        output st_ready, ks_ready, st_out_valid, st_out_data, ks_out_valid, ks_out_word, busy
    );

    modport master (
        output st_valid, st_data, ks_valid, ks_word, st_out_ready, ks_out_ready,
        input  st_ready, ks_ready, st_out_valid, st_out_data, ks_out_valid, ks_out_word, busy
    );

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter with per-requester eligibility; combinational grant, registered priority.
// A ready depends on the other side's request, never on its own; readies are held low in reset.
module aes_rr_arb2 #(
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] elig,
    output logic [1:0] rdy,
    output logic [1:0] gnt
);

    logic prio;

    assign rdy[0] = !rst && elig[0] && (!(req[1] && elig[1]) || prio == 1'b0);
    assign rdy[1] = !rst && elig[1] && (!(req[0] && elig[0]) || prio == 1'b1);
    assign gnt    = req & rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= INIT_PRIO;
        end else if (|gnt) begin
            // priority passes to the side that did not just win
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/substitution.sv
// 16 parallel S-boxes: full-state SubBytes, purely combinational.
module substitution import aes_pkg::*; (
    input  logic [0:AES_BLK_W-1] din,
    output logic [0:AES_BLK_W-1] dout
);

    for (genvar i = 0; i < AES_NBYTES; i++) begin : g_sbox
        assign dout[8*i +: 8] = aes_sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/aes_sub_arbiter.sv
// Shares one SubBytes array between full-state requests and 32-bit SubWord requests.
// Results land one cycle after accept in a per-side slot; a draining slot can be refilled the same cycle.
module aes_sub_arbiter import aes_pkg::*; #(
    parameter int KEY_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    aes_sub_arbiter_if.slave  bus
);

    logic                  st_vld_q;
    logic                  ks_vld_q;
    logic [0:AES_BLK_W-1]  st_dat_q;
    logic [0:AES_WORD_W-1] ks_dat_q;
    logic [1:0]            req;
    logic [1:0]            elig;
    logic [1:0]            rdy;
    logic [1:0]            gnt;
    logic [0:AES_BLK_W-1]  sbox_in;
    logic [0:AES_BLK_W-1]  sbox_out;

    assign req  = {bus.ks_valid, bus.st_valid};
    assign elig = {!ks_vld_q || bus.ks_out_ready, !st_vld_q || bus.st_out_ready};

    aes_rr_arb2 #(
        .INIT_PRIO ((KEY_FIRST != 0) ? GNT_KS : GNT_ST)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .elig (elig),
        .rdy  (rdy),
        .gnt  (gnt)
    );

    assign bus.st_ready = rdy[GNT_ST];
    assign bus.ks_ready = rdy[GNT_KS];

    // idle cycles feed zeros so the array does not toggle on stale operands
    always_comb begin
        sbox_in = '0;
        if (gnt[GNT_ST]) begin
            sbox_in = bus.st_data;
        end else if (gnt[GNT_KS]) begin
            sbox_in[0:AES_WORD_W-1] = bus.ks_word;
        end
    end

    substitution u_sub (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_vld_q <= 1'b0;
            ks_vld_q <= 1'b0;
            st_dat_q <= '0;
            ks_dat_q <= '0;
        end else begin
            if (gnt[GNT_ST]) begin
                st_vld_q <= 1'b1;
                st_dat_q <= sbox_out;
            end else if (bus.st_out_ready) begin
                st_vld_q <= 1'b0;
            end
            if (gnt[GNT_KS]) begin
                ks_vld_q <= 1'b1;
                ks_dat_q <= sbox_out[0:AES_WORD_W-1];
            end else if (bus.ks_out_ready) begin
                ks_vld_q <= 1'b0;
            end
        end
    end

    assign bus.st_out_valid = st_vld_q;
    assign bus.st_out_data  = st_dat_q;
    assign bus.ks_out_valid = ks_vld_q;
    assign bus.ks_out_word  = ks_dat_q;
    assign bus.busy         = st_vld_q | ks_vld_q;

endmodule

// File: tb/tb_aes_sub_arbiter.sv
// Directed test-plan scenarios followed by random traffic against a transaction-level reference model.
module tb_aes_sub_arbiter;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_sub_arbiter_if bus();

    aes_sub_arbiter #(.KEY_FIRST(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_tab [256];
    logic         m_st_v, m_ks_v, m_prio_ks;
    logic [0:127] m_st_d;
    logic [0:31]  m_ks_w;
    logic [1:0]   obs_gnt;
    logic [0:127] st_pd;
    logic [0:31]  ks_pd;
    logic [0:127] held;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1b) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from first principles: brute-force inverse, then the bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [0:127] sub_bytes(input logic [0:127] d);
        logic [0:127] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = d[8*i +: 8];
            r[8*i +: 8] = sbox_tab[b];
        end
        return r;
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        logic [0:127] r;
        r = sub_bytes({w, 96'h0});
        return r[0:31];
    endfunction

    function automatic logic [0:127] rnd_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic sv, input logic kv, input logic sor, input logic kor);
        bus.st_valid     = sv;
        bus.st_data      = st_pd;
        bus.ks_valid     = kv;
        bus.ks_word      = ks_pd;
        bus.st_out_ready = sor;
        bus.ks_out_ready = kor;
    endtask

    // One clock: check readies/grant at negedge, advance model at the edge, check slots after it
    task automatic cycle();
        logic         r, sv, kv, sor, kor, sel, kel, e_sr, e_kr;
        logic [1:0]   e_g;
        logic [0:127] sd;
        logic [0:31]  kw;
        @(negedge clk);
        r = rst; sv = bus.st_valid; kv = bus.ks_valid;
        sd = bus.st_data; kw = bus.ks_word;
        sor = bus.st_out_ready; kor = bus.ks_out_ready;
        sel = !m_st_v || sor;
        kel = !m_ks_v || kor;
        e_g = 2'b00;
        if (!r) begin
            if (sv && sel && kv && kel) e_g = m_prio_ks ? 2'b10 : 2'b01;
            else if (sv && sel)         e_g = 2'b01;
            else if (kv && kel)         e_g = 2'b10;
        end
        e_sr = !r && sel && !(kv && kel && m_prio_ks);
        e_kr = !r && kel && !(sv && sel && !m_prio_ks);
        chk("st_ready", 128'(bus.st_ready), 128'(e_sr));
        chk("ks_ready", 128'(bus.ks_ready), 128'(e_kr));
        obs_gnt = {kv & bus.ks_ready, sv & bus.st_ready};
        chk("grant", 128'(obs_gnt), 128'(e_g));
        @(posedge clk);
        #1;
        if (r) begin
            m_st_v = 1'b0; m_ks_v = 1'b0; m_st_d = '0; m_ks_w = '0; m_prio_ks = 1'b1;
        end else begin
            if (e_g[0]) begin m_st_v = 1'b1; m_st_d = sub_bytes(sd); end
            else if (sor) m_st_v = 1'b0;
            if (e_g[1]) begin m_ks_v = 1'b1; m_ks_w = sub_word(kw); end
            else if (kor) m_ks_v = 1'b0;
            if (e_g != 2'b00) m_prio_ks = e_g[0];
        end
        chk("st_out_valid", 128'(bus.st_out_valid), 128'(m_st_v));
        chk("ks_out_valid", 128'(bus.ks_out_valid), 128'(m_ks_v));
        chk("st_out_data",  128'(bus.st_out_data),  128'(m_st_d));
        chk("ks_out_word",  128'(bus.ks_out_word),  128'(m_ks_w));
        chk("busy",         128'(bus.busy),         128'(m_st_v | m_ks_v));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        m_st_v = 1'b0; m_ks_v = 1'b0; m_prio_ks = 1'b1; m_st_d = '0; m_ks_w = '0;
        st_pd = '0; ks_pd = '0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        build_sbox();
        cycle();
        cycle();
        chk("rst_busy", 128'(bus.busy), 128'(0));

        // ST only, then KS only: known-answer vectors
        st_pd = 128'h00112233445566778899aabbccddeeff;
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        chk("st_vector", 128'(bus.st_out_data), 128'h638293c31bfc33f5c4eeacea4bc12816);
        chk("st_vector_ks_idle", 128'(bus.ks_out_valid), 128'(0));
        ks_pd = 32'hcf4f3c09;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("ks_vector", 128'(bus.ks_out_word), 128'(32'h8a84eb01));
        chk("ks_vector_st_idle", 128'(bus.st_out_valid), 128'(0));

        // Contention straight after reset: KS, ST, KS, ST
        do_reset();
        st_pd = rnd_blk(); ks_pd = $urandom();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            cycle();
            chk("cont_grant", 128'(obs_gnt), (i % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
            if (obs_gnt[0]) st_pd = rnd_blk();
            if (obs_gnt[1]) ks_pd = $urandom();
        end

        // ST slot backpressured: KS served each cycle, ST result held
        held = bus.st_out_data;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            cycle();
            chk("bp_grant", 128'(obs_gnt), 128'(2'b10));
            chk("bp_hold", 128'(bus.st_out_data), 128'(held));
            if (obs_gnt[1]) ks_pd = $urandom();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("bp_refill_grant", 128'(obs_gnt), 128'(2'b01));
        chk("bp_refill_valid", 128'(bus.st_out_valid), 128'(1));
        chk("bp_refill_data", 128'(bus.st_out_data), 128'(sub_bytes(st_pd)));
        if (obs_gnt[0]) st_pd = rnd_blk();

        // Fill KS slot too, then reset mid-operation
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("pre_rst_full", 128'({bus.st_out_valid, bus.ks_out_valid}), 128'(2'b11));
        do_reset();
        chk("mid_rst_valid", 128'({bus.st_out_valid, bus.ks_out_valid}), 128'(2'b00));
        chk("mid_rst_data", 128'(bus.st_out_data), 128'(0));
        chk("mid_rst_word", 128'(bus.ks_out_word), 128'(0));
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        st_pd = rnd_blk(); ks_pd = $urandom();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("post_rst_prio", 128'(obs_gnt), 128'(2'b10));

        // ST grant, idle cycles, then contention: KS must win
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        chk("idle_st_grant", 128'(obs_gnt), 128'(2'b01));
        st_pd = rnd_blk();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("idle_then_ks", 128'(obs_gnt), 128'(2'b10));

        // Random traffic; requests held stable until accepted
        begin
            logic sp, kp;
            sp = 1'b0; kp = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if (!sp && $urandom_range(0, 9) < 6) begin sp = 1'b1; st_pd = rnd_blk(); end
                if (!kp && $urandom_range(0, 9) < 6) begin kp = 1'b1; ks_pd = $urandom(); end
                rst = ($urandom_range(0, 63) == 0);
                drive(sp, kp, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
                cycle();
                if (obs_gnt[0]) sp = 1'b0;
                if (obs_gnt[1]) kp = 1'b0;
            end
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
